// File: rtl/cd_pkg.sv
// Shared types and constants for the CD-ROM data FIFO drain engine.
package cd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    OUT,
    DONE
  } drain_state_t;

  localparam int CD_FIFO_BYTES = 16;
  localparam int CD_HW_BYTES   = 2;

  // A halfword read is only legal when a full halfword sits in the FIFO.
  function automatic logic hw_available(input logic [4:0] avail);
    return avail >= 5'(CD_HW_BYTES) && avail <= 5'(CD_FIFO_BYTES);
  endfunction

endpackage

// File: rtl/cd_hw_packer.sv
// Lo/hi halfword capture registers; presents {hi, lo} as one 32-bit little-endian word.
module cd_hw_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_lo_i,
  input  logic        load_hi_i,
  input  logic [15:0] hw_i,
  output logic [31:0] word_o
);

  logic [15:0] lo_q;
  logic [15:0] hi_q;

  // NOTE: data registers are reset too, because dma_data must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (load_lo_i) lo_q <= hw_i;
      if (load_hi_i) hi_q <= hw_i;
    end
  end

  assign word_o = {hi_q, lo_q};

endmodule

// File: rtl/cd_fifo_drain.sv
// Drains the CD sector FIFO by halfwords into 32-bit words for DMA channel 3.
// Optional CPU byte port for the odd trailing byte: define CD_DRAIN_BYTE_PORT_EN.
module cd_fifo_drain
  import cd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] word_count,
  input  logic [15:0]      fifo_data,
  input  logic [4:0]       fifo_avail,
  output logic             fifo_re_16,
  output logic             fifo_re_8,
  output logic [31:0]      dma_data,
  output logic             dma_valid,
  input  logic             dma_ready,
  output logic             busy,
`ifdef CD_DRAIN_BYTE_PORT_EN
  input  logic             cpu_rd,
  output logic [7:0]       cpu_byte,
  output logic             cpu_byte_valid,
`endif
  output logic             done
);

  drain_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             abort_q, abort_d;
  logic             dma_valid_q, busy_q, done_q;
  logic             can_read;
  logic             abort_now;

  assign can_read   = hw_available(fifo_avail);
  assign abort_now  = abort | abort_q;
  // An abort seen in LO ends the transfer before the read is issued.
  assign fifo_re_16 = can_read && ((state_q == LO && !abort_now) || state_q == HI);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (word_count != '0) begin
            count_d = word_count;
            state_d = LO;
          end else begin
            state_d = DONE;
          end
        end
      end
      LO: begin
        abort_d = abort_now;
        if (abort_now)     state_d = DONE;
        else if (can_read) state_d = HI;
      end
      HI: begin
        abort_d = abort_now;
        if (can_read) state_d = OUT;
      end
      OUT: begin
        abort_d = abort_now;
        if (dma_ready) begin
          count_d = count_q - CNT_W'(1);
          state_d = (count_q == CNT_W'(1) || abort_now) ? DONE : LO;
        end
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      abort_q     <= 1'b0;
      dma_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      abort_q     <= abort_d;
      dma_valid_q <= (state_d == OUT);
      busy_q      <= (state_d == LO) || (state_d == HI) || (state_d == OUT);
      done_q      <= (state_d == DONE);
    end
  end

  assign dma_valid = dma_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  cd_hw_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .load_lo_i (fifo_re_16 && state_q == LO),
    .load_hi_i (fifo_re_16 && state_q == HI),
    .hw_i      (fifo_data),
    .word_o    (dma_data)
  );

`ifdef CD_DRAIN_BYTE_PORT_EN
  logic       byte_rd;
  logic [7:0] cpu_byte_q;
  logic       cpu_byte_valid_q;

  // start wins over a same-cycle byte request; the request is answered with 0.
  assign byte_rd   = cpu_rd && state_q == IDLE && !start && fifo_avail != 5'd0;
  assign fifo_re_8 = byte_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_byte_q       <= 8'h00;
      cpu_byte_valid_q <= 1'b0;
    end else begin
      cpu_byte_valid_q <= cpu_rd;
      if (cpu_rd) cpu_byte_q <= byte_rd ? fifo_data[7:0] : 8'h00;
    end
  end

  assign cpu_byte       = cpu_byte_q;
  assign cpu_byte_valid = cpu_byte_valid_q;
`else
  assign fifo_re_8 = 1'b0;
`endif

endmodule

// File: tb/tb_cd_fifo_drain.sv
// Self-checking bench for cd_fifo_drain: table of normal transfers plus hand-written corner sequences.
module tb_cd_fifo_drain;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] word_count = '0;
  logic [15:0]      fifo_data;
  logic [4:0]       fifo_avail;
  logic             fifo_re_16;
  logic             fifo_re_8;
  logic [31:0]      dma_data;
  logic             dma_valid;
  logic             dma_ready = 1'b0;
  logic             busy;
  logic             done;
`ifdef CD_DRAIN_BYTE_PORT_EN
  logic             cpu_rd = 1'b0;
  logic [7:0]       cpu_byte;
  logic             cpu_byte_valid;
`endif

  always #5 clk = ~clk;

  cd_fifo_drain #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .word_count     (word_count),
    .fifo_data      (fifo_data),
    .fifo_avail     (fifo_avail),
    .fifo_re_16     (fifo_re_16),
    .fifo_re_8      (fifo_re_8),
    .dma_data       (dma_data),
    .dma_valid      (dma_valid),
    .dma_ready      (dma_ready),
    .busy           (busy),
`ifdef CD_DRAIN_BYTE_PORT_EN
    .cpu_rd         (cpu_rd),
    .cpu_byte       (cpu_byte),
    .cpu_byte_valid (cpu_byte_valid),
`endif
    .done           (done)
  );

  // Byte FIFO model: pointers only move from the main test process.
  logic [7:0] fmem [256];
  logic [7:0] frd = 8'd0;
  logic [7:0] fwr = 8'd0;
  logic [7:0] fill;
  assign fill       = fwr - frd;
  assign fifo_avail = (fill > 8'd16) ? 5'd16 : fill[4:0];
  assign fifo_data  = {fmem[8'(frd + 8'd1)], fmem[frd]};

  int checks = 0;
  int errors = 0;
  int rd16_cnt, rd8_cnt, re8_total, done_cnt, word_cnt;
  int proto_err = 0;
  int stab_err  = 0;
  logic [31:0] first_w, last_w, prev_data;
  logic        prev_valid, prev_ready, last_done;

  typedef struct {
    logic [15:0] wc;
    logic [7:0]  base;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_reads;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[fwr] = b;
    fwr = fwr + 8'd1;
  endtask

  task automatic clear_stats();
    rd16_cnt   = 0;
    rd8_cnt    = 0;
    done_cnt   = 0;
    word_cnt   = 0;
    first_w    = '0;
    last_w     = '0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    last_done  = 1'b0;
  endtask

  // Observe one cycle just before its closing edge, then advance the FIFO model.
  task automatic tick();
    logic re16, re8;
    #1;
    re16 = fifo_re_16;
    re8  = fifo_re_8;
    if (re16 && fifo_avail < 5'd2) proto_err++;
    if (re16 && re8) proto_err++;
    if (re8 && fifo_avail == 5'd0) proto_err++;
    if (prev_valid && !prev_ready && (!dma_valid || dma_data !== prev_data)) stab_err++;
    if (dma_valid && dma_ready) begin
      if (word_cnt == 0) first_w = dma_data;
      last_w = dma_data;
      word_cnt++;
    end
    last_done = done;
    if (done) done_cnt++;
    prev_valid = dma_valid;
    prev_ready = dma_ready;
    prev_data  = dma_data;
    @(posedge clk);
    #1;
    if (re16) begin
      frd = frd + 8'd2;
      rd16_cnt++;
    end
    if (re8) begin
      frd = frd + 8'd1;
      rd8_cnt++;
      re8_total++;
    end
  endtask

  task automatic run_to_done(input int budget, output int cyc);
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (last_done) begin
        cyc = n;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    re8_total = 0;
    clear_stats();

    vecs[0] = '{16'd2, 8'h00, 2, 32'h03020100, 32'h07060504, 4, 7};
    vecs[1] = '{16'd1, 8'h10, 1, 32'h13121110, 32'h13121110, 2, 4};
    vecs[2] = '{16'd3, 8'hA0, 3, 32'hA3A2A1A0, 32'hABAAA9A8, 6, 10};
    vecs[3] = '{16'd0, 8'h00, 0, 32'h00000000, 32'h00000000, 0, 1};
    vecs[4] = '{16'd4, 8'h40, 4, 32'h43424140, 32'h4F4E4D4C, 8, 13};

    // Reset state.
    @(negedge clk);
    check("rst_re16", fifo_re_16, 0);
    check("rst_re8", fifo_re_8, 0);
    check("rst_valid", dma_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", dma_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check("idle_busy", busy, 0);
    check("idle_reads", rd16_cnt, 0);

    // Table of normal transfers with dma_ready tied high.
    dma_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      clear_stats();
      for (int i = 0; i < 4 * int'(vecs[v].wc); i++) push(vecs[v].base + 8'(i));
      word_count = vecs[v].wc;
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to_done(60, cyc);
      check($sformatf("v%0d_words", v), word_cnt, vecs[v].exp_words);
      check($sformatf("v%0d_first", v), first_w, vecs[v].exp_first);
      check($sformatf("v%0d_last", v), last_w, vecs[v].exp_last);
      check($sformatf("v%0d_reads", v), rd16_cnt, vecs[v].exp_reads);
      check($sformatf("v%0d_done_cycle", v), cyc, vecs[v].exp_cyc);
      tick();
      check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
      check($sformatf("v%0d_busy_after", v), busy, 0);
      check($sformatf("v%0d_fifo_left", v), fill, 0);
    end

    // Starved FIFO, ignored restart, and a 5-cycle DMA stall.
    clear_stats();
    dma_ready = 1'b0;
    push(8'h50);
    word_count = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("starve_reads", rd16_cnt, 0);
    check("starve_busy", busy, 1);
    word_count = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    word_count = '0;
    for (int i = 1; i < 8; i++) push(8'h50 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      if (dma_valid) break;
      tick();
    end
    check("stall_valid", dma_valid, 1);
    check("stall_data0", dma_data, 32'h53525150);
    repeat (5) tick();
    check("stall_hold_valid", dma_valid, 1);
    check("stall_hold_data", dma_data, 32'h53525150);
    check("stall_stable", stab_err, 0);
    check("stall_no_accept", word_cnt, 0);
    dma_ready = 1'b1;
    run_to_done(30, cyc);
    check("stall_words", word_cnt, 2);
    check("stall_last", last_w, 32'h57565554);
    check("stall_reads", rd16_cnt, 4);
    check("stall_done", done_cnt, 1);

    // Abort while in HI: the word in flight still goes out.
    clear_stats();
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    word_count = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_to_done(20, cyc);
    check("abort_words", word_cnt, 1);
    check("abort_word", first_w, 32'h63626160);
    check("abort_reads", rd16_cnt, 2);
    check("abort_done_cycle", cyc, 2);
    frd = fwr;

    // Reset while a word is waiting in OUT.
    clear_stats();
    dma_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
    word_count = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_valid", dma_valid, 1);
    #2 rst = 1'b1;
    prev_valid = 1'b0;
    #1;
    check("mid_rst_valid", dma_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    frd = fwr;
    repeat (3) tick();
    check("mid_rst_done", done_cnt, 0);
    check("mid_rst_idle", busy, 0);

`ifdef CD_DRAIN_BYTE_PORT_EN
    // Byte port: one real byte, then a request against an empty FIFO.
    clear_stats();
    push(8'hA5);
    cpu_rd = 1'b1;
    #1;
    check("byte_re8", fifo_re_8, 1);
    tick();
    cpu_rd = 1'b0;
    check("byte_valid", cpu_byte_valid, 1);
    check("byte_value", cpu_byte, 8'hA5);
    check("byte_reads", rd8_cnt, 1);
    tick();
    check("byte_valid_pulse", cpu_byte_valid, 0);
    cpu_rd = 1'b1;
    #1;
    check("empty_re8", fifo_re_8, 0);
    tick();
    cpu_rd = 1'b0;
    check("empty_valid", cpu_byte_valid, 1);
    check("empty_value", cpu_byte, 8'h00);
    check("empty_reads", rd8_cnt, 1);
`else
    check("no_byte_reads", re8_total, 0);
`endif

    check("protocol", proto_err, 0);
    check("stability", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_fifo_drain.md
# cd_fifo_drain

Consumer-side engine for the CD-ROM data FIFO: drains the 8-bit-write / 16-bit-read sector data FIFO by halfwords, packs pairs into 32-bit little-endian words, and hands them to DMA channel 3 over a valid/ready handshake. It sits between the CD data FIFO and the DMA controller, replacing ad-hoc CPU/DMA FIFO reads with one sequenced transfer of a programmed word count.

## Interface
Parameters:
- CNT_W, 16, width of the word-count register (max transfer 2^CNT_W-1 words)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse, begins a transfer; ignored while busy
- abort  in  1  one-cycle pulse, terminates a transfer at the next state boundary
- word_count  in  CNT_W  32-bit words to transfer; sampled on start
- fifo_data  in  16  FIFO halfword at the read pointer; byte 0 in [7:0]
- fifo_avail  in  5  bytes currently held in the FIFO (0..16)
- fifo_re_16  out  1  consume two bytes this cycle
- fifo_re_8  out  1  consume one byte this cycle (byte port only)
- dma_data  out  32  packed word, {hi halfword, lo halfword}
- dma_valid  out  1  dma_data valid; held until dma_ready
- dma_ready  in  1  DMA accepts word when valid && ready
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end (normal or abort)
- cpu_rd  in  1  one-cycle CPU byte-read request (CD_DRAIN_BYTE_PORT_EN)
- cpu_byte  out  8  registered byte result (CD_DRAIN_BYTE_PORT_EN)
- cpu_byte_valid  out  1  one-cycle pulse with cpu_byte (CD_DRAIN_BYTE_PORT_EN)

## Operation
- States: IDLE, LO, HI, OUT, DONE.
- IDLE: start with word_count≠0 → latch count, busy=1, → LO. start with word_count=0 → DONE directly.
- LO: if fifo_avail≥2, assert fifo_re_16, capture fifo_data into lo half, → HI; else wait (no read).
- HI: same rule, capture into hi half, → OUT.
- OUT: dma_valid=1, dma_data stable. On dma_ready: decrement count; count reaches 0 → DONE, else → LO.
- DONE: done=1 for one cycle, busy=0, → IDLE.
- abort: sampled in any busy state; takes effect when in LO (before read) or on OUT handshake; current word in OUT is still delivered. An abort in HI completes the HI read, delivers the word, then ends. Next state DONE.
- Never read with fifo_avail<2; a single odd byte is left in the FIFO for the byte port.
- fifo_re_8 and fifo_re_16 never asserted in the same cycle.
- Count arithmetic: CNT_W-bit unsigned, no wrap; decrement only on handshake.

## Timing
- Reset: state IDLE; fifo_re_16, fifo_re_8, dma_valid, busy, done, cpu_byte_valid = 0; dma_data, cpu_byte = 0.
- fifo_data is combinational from the FIFO; it is sampled in the same cycle fifo_re_16 is high.
- start at cycle 0 with fifo_avail≥4: fifo_re_16 in cycles 1 and 2, dma_valid from cycle 3.
- With dma_ready tied high: one word per 3 cycles; done 1 cycle after final handshake.
- dma_valid may not drop without dma_ready; dma_data constant while valid.
- start during busy: ignored, no effect on count.
- Reset mid-transfer: immediate return to IDLE, no done pulse.

## Configuration
- CD_DRAIN_BYTE_PORT_EN defined: cpu_rd in IDLE with fifo_avail≥1 → fifo_re_8 that cycle, cpu_byte=fifo_data[7:0] and cpu_byte_valid next cycle. cpu_rd while busy or fifo_avail=0 → cpu_byte=8'h00 with cpu_byte_valid, no FIFO read. cpu_rd and start same cycle: start wins, byte request answered with 8'h00.
- Not defined: cpu_rd/cpu_byte/cpu_byte_valid ports removed, fifo_re_8 tied 0.

## Structure
- cd_pkg: drain_state_t enum (IDLE, LO, HI, OUT, DONE), CD_FIFO_BYTES=16, CD_HW_BYTES=2.
- Sub-module cd_hw_packer: lo/hi halfword capture registers with load strobes, outputs 32-bit word; FSM stays in cd_fifo_drain.

## Test plan
- Reset: all outputs 0, state IDLE, busy 0, no FIFO reads.
- word_count=2, FIFO bytes 0x00..0x07, dma_ready=1 → dma_data 0x03020100 then 0x07060504, done pulse, 4 fifo_re_16 total.
- fifo_avail=1 after start → no reads until avail rises to 2; dma_ready held low 5 cycles in OUT → dma_data/valid stable, count unchanged.
- word_count=0 → done 1 cycle after start, no reads, no dma_valid; start during busy ignored.
- abort in HI with word_count=8 → word still delivered, done next, exactly 2 FIFO reads; reset mid-OUT → dma_valid 0 immediately, no done.
- Byte port enabled: FIFO holds 0xA5, cpu_rd in IDLE → fifo_re_8 one cycle, cpu_byte=0xA5; cpu_rd with avail=0 → 0x00, no read.
